// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion scheduler: FSM states, engine
// offsets, config register map and default playfield limits.
package sprite_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC0,
        S_WR0,
        S_CALC1,
        S_WR1,
        S_HOST,
        S_DONE
    } state_t;

    localparam logic [5:0] ENG_SPR0_POS = 6'h04;
    localparam logic [5:0] ENG_SPR1_POS = 6'h1A;

    localparam logic [2:0] CFG_CTRL = 3'd0;
    localparam logic [2:0] CFG_POS0 = 3'd1;
    localparam logic [2:0] CFG_VEL0 = 3'd2;
    localparam logic [2:0] CFG_POS1 = 3'd3;
    localparam logic [2:0] CFG_VEL1 = 3'd4;

    localparam int XMAX_DEF = 244;
    localparam int YMAX_DEF = 180;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis bounce step: moves pos by a signed 4-bit velocity and reflects the
// velocity when the result would leave [0, max_pos].
module sprite_axis_step (
    input  logic        [7:0] pos,
    input  logic signed [3:0] vel,
    input  logic        [7:0] max_pos,
    output logic        [7:0] pos_next,
    output logic signed [3:0] vel_next
);

    // -(-8) does not fit in 4 bits, so it clamps to +7.
    function automatic logic signed [3:0] neg_sat(input logic signed [3:0] v);
        if (v == -4'sd8) begin
            return 4'sd7;
        end
        return -v;
    endfunction

    logic signed [9:0] n;
    logic signed [9:0] lim;

    assign n   = $signed({2'b00, pos}) + $signed({{6{vel[3]}}, vel});
    assign lim = $signed({2'b00, max_pos});

    always_comb begin
        pos_next = pos;
        vel_next = vel;
        if (vel != 4'sd0) begin
            if (n < 10'sd0) begin
                pos_next = 8'd0;
                vel_next = neg_sat(vel);
            end else if (n > lim) begin
                pos_next = max_pos;
                vel_next = neg_sat(vel);
            end else begin
                pos_next = n[7:0];
            end
        end
    end

endmodule

// File: rtl/sprite_motion_sched.sv
// Frame-divided sprite position updater with bounce, sharing a valid/ready
// engine write port with host-originated writes.
module sprite_motion_sched
    import sprite_pkg::*;
#(
    parameter int XMAX = XMAX_DEF,
    parameter int YMAX = YMAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [5:0]  host_addr,
    input  logic [15:0] host_data,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic [5:0]  eng_addr,
    output logic [15:0] eng_data,
    output logic [15:0] pos0,
    output logic [15:0] pos1,
    output logic        done,
    output logic        overrun
);

    localparam logic [7:0] XMAX_B = 8'(XMAX);
    localparam logic [7:0] YMAX_B = 8'(YMAX);

    state_t      state, state_nxt;
    logic        en0, en1, pend;
    logic [3:0]  div, fcnt;
    logic [7:0]  vel0, vel1;
    logic [15:0] pos0_nxt, pos1_nxt;
    logic [7:0]  vel0_nxt, vel1_nxt;
    logic [7:0]  nx0, ny0, nx1, ny1;
    logic signed [3:0] nvx0, nvy0, nvx1, nvy1;
    logic        tick_hit, ctrl_wr;

    assign tick_hit = frame_tick && (fcnt == div);
    assign ctrl_wr  = cfg_we && (cfg_addr == CFG_CTRL);

    sprite_axis_step u_s0x (.pos(pos0[7:0]),  .vel(vel0[3:0]), .max_pos(XMAX_B), .pos_next(nx0), .vel_next(nvx0));
    sprite_axis_step u_s0y (.pos(pos0[15:8]), .vel(vel0[7:4]), .max_pos(YMAX_B), .pos_next(ny0), .vel_next(nvy0));
    sprite_axis_step u_s1x (.pos(pos1[7:0]),  .vel(vel1[3:0]), .max_pos(XMAX_B), .pos_next(nx1), .vel_next(nvx1));
    sprite_axis_step u_s1y (.pos(pos1[15:8]), .vel(vel1[7:4]), .max_pos(YMAX_B), .pos_next(ny1), .vel_next(nvy1));

    // Computed motion first, then a same-cycle config write overrides it.
    always_comb begin
        pos0_nxt = pos0;
        vel0_nxt = vel0;
        pos1_nxt = pos1;
        vel1_nxt = vel1;
        if (state == S_CALC0 && en0) begin
            pos0_nxt = {ny0, nx0};
            vel0_nxt = {nvy0, nvx0};
        end
        if (state == S_CALC1 && en1) begin
            pos1_nxt = {ny1, nx1};
            vel1_nxt = {nvy1, nvx1};
        end
        if (cfg_we) begin
            case (cfg_addr)
                CFG_POS0: pos0_nxt = cfg_wdata;
                CFG_VEL0: vel0_nxt = cfg_wdata[7:0];
                CFG_POS1: pos1_nxt = cfg_wdata;
                CFG_VEL1: vel1_nxt = cfg_wdata[7:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        host_ready = 1'b0;
        eng_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    state_nxt = S_CALC0;
                end else if (host_valid) begin
                    host_ready = 1'b1;
                    state_nxt  = S_HOST;
                end
            end
            S_CALC0: state_nxt = en0 ? S_WR0 : S_CALC1;
            S_WR0: begin
                eng_valid = 1'b1;
                if (eng_ready) state_nxt = S_CALC1;
            end
            S_CALC1: state_nxt = en1 ? S_WR1 : S_DONE;
            S_WR1: begin
                eng_valid = 1'b1;
                if (eng_ready) state_nxt = S_DONE;
            end
            S_HOST: begin
                eng_valid = 1'b1;
                if (eng_ready) state_nxt = S_IDLE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            en0      <= 1'b0;
            en1      <= 1'b0;
            div      <= 4'd0;
            fcnt     <= 4'd0;
            pend     <= 1'b0;
            overrun  <= 1'b0;
            pos0     <= 16'd0;
            pos1     <= 16'd0;
            vel0     <= 8'd0;
            vel1     <= 8'd0;
            eng_addr <= 6'd0;
            eng_data <= 16'd0;
        end else begin
            state <= state_nxt;
            pos0  <= pos0_nxt;
            pos1  <= pos1_nxt;
            vel0  <= vel0_nxt;
            vel1  <= vel1_nxt;
            if (ctrl_wr) begin
                en0 <= cfg_wdata[0];
                en1 <= cfg_wdata[1];
                div <= cfg_wdata[7:4];
            end
            if (frame_tick) begin
                fcnt <= tick_hit ? 4'd0 : fcnt + 4'd1;
            end
            // A new scheduled tick re-arms pend even in the cycle IDLE consumes it.
            if (tick_hit) begin
                pend <= 1'b1;
            end else if (state == S_IDLE) begin
                pend <= 1'b0;
            end
            if (ctrl_wr && cfg_wdata[8]) overrun <= 1'b0;
            if (tick_hit && pend)        overrun <= 1'b1;
            // Engine address/data are captured on entry to a write state so they
            // cannot move while the engine is stalling.
            case (state)
                S_IDLE: begin
                    if (!pend && host_valid) begin
                        eng_addr <= host_addr;
                        eng_data <= host_data;
                    end
                end
                S_CALC0: begin
                    if (en0) begin
                        eng_addr <= ENG_SPR0_POS;
                        eng_data <= pos0_nxt;
                    end
                end
                S_CALC1: begin
                    if (en1) begin
                        eng_addr <= ENG_SPR1_POS;
                        eng_data <= pos1_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Directed bench for sprite_motion_sched: motion/bounce values, divider,
// host arbitration under stall, overrun and mid-sequence reset.
module tb_sprite_motion_sched;

    logic        clk = 1'b0;
    logic        rst, frame_tick, cfg_we, host_valid, host_ready;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata, host_data, eng_data, pos0, pos1;
    logic [5:0]  host_addr, eng_addr;
    logic        eng_valid, eng_ready, done, overrun;

    sprite_motion_sched dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .eng_valid(eng_valid), .eng_ready(eng_ready),
        .eng_addr(eng_addr), .eng_data(eng_data),
        .pos0(pos0), .pos1(pos1), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          cyc = 0;
    int          wr_n = 0;
    logic [5:0]  wr_addr [64];
    logic [15:0] wr_data [64];
    int          wr_cyc  [64];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stab_err = 0;
    logic        stall_q = 1'b0;
    logic [5:0]  st_addr;
    logic [15:0] st_data;
    int          tick_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine-side log plus a valid/ready stability watch.
    always @(posedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && (!eng_valid || eng_addr != st_addr || eng_data != st_data))
                stab_err <= stab_err + 1;
            if (eng_valid && eng_ready) begin
                wr_addr[wr_n] <= eng_addr;
                wr_data[wr_n] <= eng_data;
                wr_cyc[wr_n]  <= cyc;
                wr_n          <= wr_n + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            stall_q <= eng_valid && !eng_ready;
            st_addr <= eng_addr;
            st_data <= eng_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycles(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(posedge clk);
        tick_cyc = cyc;
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 100) begin
            cycles(1);
            k++;
        end
        chk("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    int base, d0, hr_acc, found;

    initial begin
        rst = 1'b1; frame_tick = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 16'd0;
        host_valid = 1'b0; host_addr = 6'd0; host_data = 16'd0; eng_ready = 1'b1;
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_eng_valid", 32'(eng_valid), 0);
        chk("rst_host_ready", 32'(host_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_pos0", 32'(pos0), 0);
        cycles(1);

        // Basic step, sprite 0 only.
        cfg_write(3'd0, 16'h0001);
        cfg_write(3'd1, 16'h0A14);
        cfg_write(3'd2, 16'h00E3);
        base = wr_n; d0 = done_cnt;
        pulse_tick();
        wait_done(d0 + 1);
        cycles(2);
        chk("t1_latency", 32'(done_cyc - tick_cyc), 32'd5);
        chk("t1_nwr", 32'(wr_n - base), 32'd1);
        chk("t1_addr", 32'(wr_addr[base]), 32'h04);
        chk("t1_data", 32'(wr_data[base]), 32'h0817);
        chk("t1_pos0", 32'(pos0), 32'h0817);

        // Right-edge bounce, then reflected velocity.
        cfg_write(3'd1, 16'h0AF3);
        cfg_write(3'd2, 16'h0003);
        base = wr_n; d0 = done_cnt;
        pulse_tick(); wait_done(d0 + 1); cycles(1);
        pulse_tick(); wait_done(d0 + 2); cycles(1);
        chk("t2_edge", 32'(wr_data[base]), 32'h0AF4);
        chk("t2_back", 32'(wr_data[base + 1]), 32'h0AF1);

        // Left-edge bounce with -8 saturating to +7.
        cfg_write(3'd1, 16'h0A05);
        cfg_write(3'd2, 16'h0008);
        base = wr_n; d0 = done_cnt;
        pulse_tick(); wait_done(d0 + 1); cycles(1);
        pulse_tick(); wait_done(d0 + 2); cycles(1);
        chk("t3_zero", 32'(wr_data[base]), 32'h0A00);
        chk("t3_sat7", 32'(wr_data[base + 1]), 32'h0A07);

        // Divider of 2: only the third tick schedules an update.
        cfg_write(3'd0, 16'h0021);
        base = wr_n; d0 = done_cnt;
        pulse_tick(); cycles(3);
        pulse_tick(); cycles(8);
        chk("t4_no_early", 32'(done_cnt), 32'(d0));
        pulse_tick();
        wait_done(d0 + 1);
        cycles(8);
        chk("t4_one_seq", 32'(done_cnt), 32'(d0 + 1));
        chk("t4_nwr", 32'(wr_n - base), 32'd1);
        chk("t4_data", 32'(wr_data[base]), 32'h0A0E);

        // Both sprites, nominal timing.
        cfg_write(3'd0, 16'h0003);
        cfg_write(3'd1, 16'h0A14);
        cfg_write(3'd2, 16'h00E3);
        cfg_write(3'd3, 16'h6432);
        cfg_write(3'd4, 16'h001F);
        base = wr_n; d0 = done_cnt;
        pulse_tick();
        wait_done(d0 + 1);
        cycles(2);
        chk("t5_latency", 32'(done_cyc - tick_cyc), 32'd6);
        chk("t5_a0", 32'(wr_addr[base]), 32'h04);
        chk("t5_d0", 32'(wr_data[base]), 32'h0817);
        chk("t5_a1", 32'(wr_addr[base + 1]), 32'h1A);
        chk("t5_d1", 32'(wr_data[base + 1]), 32'h6531);

        // Host request held across a stalled sprite write.
        cfg_write(3'd1, 16'h0A14);
        cfg_write(3'd3, 16'h6432);
        base = wr_n; d0 = done_cnt;
        eng_ready = 1'b0;
        pulse_tick();
        host_valid = 1'b1; host_addr = 6'h06; host_data = 16'hBEEF;
        hr_acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hr_acc |= 32'(host_ready);
            if (i >= 2) begin
                chk("t6_stall_valid", 32'(eng_valid), 1);
                chk("t6_stall_data", 32'(eng_data), 32'h0817);
            end
        end
        cycles(1);
        eng_ready = 1'b1;
        chk("t6_no_host_ready", 32'(hr_acc), 0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (host_ready) found = 1;
        end
        chk("t6_host_ready", 32'(found), 1);
        cycles(1);
        host_valid = 1'b0;
        cycles(4);
        chk("t6_nwr", 32'(wr_n - base), 32'd3);
        chk("t6_host_addr", 32'(wr_addr[base + 2]), 32'h06);
        chk("t6_host_data", 32'(wr_data[base + 2]), 32'hBEEF);
        chk("t6_after_done", 32'(wr_cyc[base + 2] > done_cyc), 1);
        chk("t6_done_once", 32'(done_cnt), 32'(d0 + 1));

        // Overrun: extra ticks pile up while the engine is stalled.
        base = wr_n; d0 = done_cnt;
        eng_ready = 1'b0;
        pulse_tick(); cycles(3);
        pulse_tick();
        pulse_tick();
        @(negedge clk);
        chk("t7_overrun", 32'(overrun), 1);
        cycles(1);
        eng_ready = 1'b1;
        wait_done(d0 + 2);
        cycles(2);
        chk("t7_nwr", 32'(wr_n - base), 32'd4);
        chk("t7_d0", 32'(wr_data[base]), 32'h061A);
        chk("t7_d1", 32'(wr_data[base + 1]), 32'h6630);
        chk("t7_d2", 32'(wr_data[base + 2]), 32'h041D);
        chk("t7_d3", 32'(wr_data[base + 3]), 32'h672F);
        chk("t7_still_sticky", 32'(overrun), 1);
        cfg_write(3'd0, 16'h0103);
        @(negedge clk);
        chk("t7_cleared", 32'(overrun), 0);
        cycles(1);

        // Reset while WR1 is stalled.
        cfg_write(3'd0, 16'h0002);
        d0 = done_cnt;
        eng_ready = 1'b0;
        pulse_tick();
        cycles(3);
        @(negedge clk);
        chk("t8_in_wr1", 32'(eng_valid), 1);
        chk("t8_addr", 32'(eng_addr), 32'h1A);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t8_abandon", 32'(eng_valid), 0);
        chk("t8_pos1_rst", 32'(pos1), 0);
        eng_ready = 1'b1;
        cycles(10);
        chk("t8_no_done", 32'(done_cnt), 32'(d0));
        chk("stability", 32'(stab_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
